// File: rtl/key_action_gen.sv
// key_action_gen: turns debounced, held button levels into single-cycle key_* action pulses.
// Left/right share one delayed-auto-shift / auto-repeat FSM in which the last press wins.
// Down repeats every SOFT_MS ticks while held. Rotate, drop and hold fire once per press.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   tick_ms              1-cycle timing strobe; every timer counts these
//   en                   1 = accept input, 0 = suppress all actions and idle the FSMs
//   btn_*                held button levels, synchronous to clk
//   key_*                registered 1-cycle action pulses
//   key_drop_held        registered btn_drop & en
module key_action_gen #(
  parameter int unsigned DAS_MS  = 170,
  parameter int unsigned ARR_MS  = 50,
  parameter int unsigned SOFT_MS = 33,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_ms,
  input  logic en,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_down,
  input  logic btn_rot_cw,
  input  logic btn_rot_ccw,
  input  logic btn_drop,
  input  logic btn_hold,
  output logic key_left,
  output logic key_right,
  output logic key_down,
  output logic key_rotate_cw,
  output logic key_rotate_ccw,
  output logic key_drop,
  output logic key_hold,
  output logic key_drop_held
);

  localparam int unsigned NBTN = 7;
  localparam logic [CNT_W-1:0] DAS_END  = CNT_W'(DAS_MS - 1);
  localparam logic [CNT_W-1:0] ARR_END  = CNT_W'(ARR_MS - 1);
  localparam logic [CNT_W-1:0] SOFT_END = CNT_W'(SOFT_MS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {H_IDLE, H_DAS, H_ARR} h_state_e;

  // Saturating increment so a timer can never wrap back into a match
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [NBTN-1:0] btn_vec, prev_q, edge_v;
  h_state_e        h_state_q, h_state_d;
  logic            dir_q, dir_d;          // 0 = left, 1 = right
  logic [CNT_W-1:0] h_tmr_q, h_tmr_d;
  logic [CNT_W-1:0] d_tmr_q, d_tmr_d;
  logic            d_act_q, d_act_d;      // down was pressed while enabled
  logic            hp_c, hp_dir_c;        // horizontal pulse and its direction
  logic            held_dir_c, opp_edge_c;
  logic            left_d, right_d, down_d, cw_d, ccw_d, drop_d, hold_d;

  assign btn_vec = {btn_hold, btn_drop, btn_rot_ccw, btn_rot_cw, btn_down, btn_right, btn_left};
  assign edge_v  = btn_vec & ~prev_q;

  // Next-state and pulse decisions
  always_comb begin
    h_state_d  = h_state_q;
    dir_d      = dir_q;
    h_tmr_d    = h_tmr_q;
    d_tmr_d    = d_tmr_q;
    d_act_d    = d_act_q;
    hp_c       = 1'b0;
    hp_dir_c   = dir_q;
    down_d     = 1'b0;
    cw_d       = 1'b0;
    ccw_d      = 1'b0;
    drop_d     = 1'b0;
    hold_d     = 1'b0;
    held_dir_c = dir_q ? btn_right : btn_left;
    opp_edge_c = dir_q ? edge_v[0] : edge_v[1];

    if (!en) begin
      h_state_d = H_IDLE;
      dir_d     = 1'b0;
      h_tmr_d   = '0;
      d_tmr_d   = '0;
      d_act_d   = 1'b0;
    end else begin
      case (h_state_q)
        H_IDLE: begin
          // Left wins a same-cycle left/right press
          if (edge_v[0] || edge_v[1]) begin
            h_state_d = H_DAS;
            dir_d     = ~edge_v[0];
            h_tmr_d   = '0;
            hp_c      = 1'b1;
            hp_dir_c  = ~edge_v[0];
          end
        end
        H_DAS, H_ARR: begin
          if (opp_edge_c) begin
            h_state_d = H_DAS;
            dir_d     = ~dir_q;
            h_tmr_d   = '0;
            hp_c      = 1'b1;
            hp_dir_c  = ~dir_q;
          end else if (!held_dir_c) begin
            // No resume of the other direction; it needs a fresh press
            h_state_d = H_IDLE;
            h_tmr_d   = '0;
          end else if (tick_ms) begin
            if (h_tmr_q == ((h_state_q == H_DAS) ? DAS_END : ARR_END)) begin
              h_state_d = H_ARR;
              h_tmr_d   = '0;
              hp_c      = 1'b1;
            end else begin
              h_tmr_d = sat_inc(h_tmr_q);
            end
          end
        end
        default: begin
          h_state_d = H_IDLE;
          h_tmr_d   = '0;
        end
      endcase

      // Soft drop: immediate pulse, then one every SOFT_MS ticks while held
      if (edge_v[2]) begin
        down_d  = 1'b1;
        d_act_d = 1'b1;
        d_tmr_d = '0;
      end else if (!btn_down) begin
        d_act_d = 1'b0;
        d_tmr_d = '0;
      end else if (d_act_q && tick_ms) begin
        if (d_tmr_q == SOFT_END) begin
          down_d  = 1'b1;
          d_tmr_d = '0;
        end else begin
          d_tmr_d = sat_inc(d_tmr_q);
        end
      end

      cw_d   = edge_v[3];
      ccw_d  = edge_v[4] & ~edge_v[3];
      drop_d = edge_v[5];
      hold_d = edge_v[6];
    end
  end

  assign left_d  = hp_c & ~hp_dir_c;
  assign right_d = hp_c & hp_dir_c;

  // State, timers, edge history and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q         <= '0;
      h_state_q      <= H_IDLE;
      dir_q          <= 1'b0;
      h_tmr_q        <= '0;
      d_tmr_q        <= '0;
      d_act_q        <= 1'b0;
      key_left       <= 1'b0;
      key_right      <= 1'b0;
      key_down       <= 1'b0;
      key_rotate_cw  <= 1'b0;
      key_rotate_ccw <= 1'b0;
      key_drop       <= 1'b0;
      key_hold       <= 1'b0;
      key_drop_held  <= 1'b0;
    end else begin
      prev_q         <= btn_vec;
      h_state_q      <= h_state_d;
      dir_q          <= dir_d;
      h_tmr_q        <= h_tmr_d;
      d_tmr_q        <= d_tmr_d;
      d_act_q        <= d_act_d;
      key_left       <= left_d;
      key_right      <= right_d;
      key_down       <= down_d;
      key_rotate_cw  <= cw_d;
      key_rotate_ccw <= ccw_d;
      key_drop       <= drop_d;
      key_hold       <= hold_d;
      key_drop_held  <= btn_drop & en;
    end
  end

endmodule

// File: tb/tb_key_action_gen.sv
// Testbench for key_action_gen: directed scenarios plus random button traffic,
// checked every cycle against a tick-count reference model.
module tb_key_action_gen;

  localparam int unsigned DAS  = 4;
  localparam int unsigned ARR  = 2;
  localparam int unsigned SOFT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic en = 1'b0;
  logic [6:0] b = '0;   // 0 left,1 right,2 down,3 cw,4 ccw,5 drop,6 hold

  logic key_left, key_right, key_down, key_rotate_cw, key_rotate_ccw;
  logic key_drop, key_hold, key_drop_held;
  logic [7:0] got;
  logic [7:0] exp_v;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cnt[8];
  bit tick_rand = 1'b0;
  string names[8] = '{"key_left", "key_right", "key_down", "key_rotate_cw",
                      "key_rotate_ccw", "key_drop", "key_hold", "key_drop_held"};

  // Reference model: direction held (0 none,1 left,2 right) and ticks since its press
  int m_dir = 0;
  int m_ht = 0;
  bit m_dact = 1'b0;
  int m_dt = 0;
  logic [6:0] m_prev = '0;

  key_action_gen #(.DAS_MS(DAS), .ARR_MS(ARR), .SOFT_MS(SOFT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick_ms(tick), .en(en),
    .btn_left(b[0]), .btn_right(b[1]), .btn_down(b[2]), .btn_rot_cw(b[3]),
    .btn_rot_ccw(b[4]), .btn_drop(b[5]), .btn_hold(b[6]),
    .key_left(key_left), .key_right(key_right), .key_down(key_down),
    .key_rotate_cw(key_rotate_cw), .key_rotate_ccw(key_rotate_ccw),
    .key_drop(key_drop), .key_hold(key_hold), .key_drop_held(key_drop_held)
  );

  assign got = {key_drop_held, key_hold, key_drop, key_rotate_ccw,
                key_rotate_cw, key_down, key_right, key_left};

  always #5 clk = ~clk;

  task automatic model_reset();
    m_dir = 0; m_ht = 0; m_dact = 1'b0; m_dt = 0; m_prev = '0;
  endtask

  // Expected outputs after the coming clock edge, from the current inputs
  task automatic model_eval();
    logic [6:0] e;
    e = b & ~m_prev;
    exp_v = '0;
    if (!en) begin
      m_dir = 0;
      m_dact = 1'b0;
    end else begin
      if (m_dir == 0) begin
        if (e[0]) begin m_dir = 1; m_ht = 0; exp_v[0] = 1'b1; end
        else if (e[1]) begin m_dir = 2; m_ht = 0; exp_v[1] = 1'b1; end
      end else if ((m_dir == 1 && e[1]) || (m_dir == 2 && e[0])) begin
        m_dir = 3 - m_dir; m_ht = 0; exp_v[m_dir-1] = 1'b1;
      end else if (!b[m_dir-1]) begin
        m_dir = 0;
      end else if (tick) begin
        m_ht++;
        if (m_ht == DAS || (m_ht > DAS && (m_ht - DAS) % ARR == 0)) exp_v[m_dir-1] = 1'b1;
      end
      if (e[2]) begin m_dact = 1'b1; m_dt = 0; exp_v[2] = 1'b1; end
      else if (!b[2]) m_dact = 1'b0;
      else if (m_dact && tick) begin
        m_dt++;
        if (m_dt % SOFT == 0) exp_v[2] = 1'b1;
      end
      exp_v[3] = e[3];
      exp_v[4] = e[4] & ~e[3];
      exp_v[5] = e[5];
      exp_v[6] = e[6];
    end
    exp_v[7] = b[5] & en;
    m_prev = b;
  endtask

  task automatic check_outputs(input logic [7:0] e);
    for (int i = 0; i < 8; i++) begin
      total++;
      assert (got[i] === e[i]) else begin
        bad++;
        $error("FAIL %s cyc=%0d observed=%b expected=%b", names[i], cyc, got[i], e[i]);
      end
    end
  endtask

  task automatic check_cnt(input string tag, input int idx, input int expv);
    total++;
    assert (cnt[idx] === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, cnt[idx], expv);
    end
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < 8; i++) cnt[i] = 0;
  endtask

  task automatic step();
    tick = tick_rand ? ($urandom_range(3) == 0) : ((cyc % 10) == 9);
    model_eval();
    @(posedge clk);
    #1;
    check_outputs(exp_v);
    for (int i = 0; i < 8; i++) cnt[i] += int'(got[i]);
    cyc++;
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic align();
    while ((cyc % 10) != 0) step();
  endtask

  initial begin
    clear_cnt();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs(8'h00);
    rst_n = 1'b1;
    en = 1'b1;
    step_n(5);

    // Left held 9 ticks: press pulse + ticks 4, 6, 8
    align();
    clear_cnt();
    b[0] = 1'b1; step_n(90);
    b[0] = 1'b0; step_n(1);
    check_cnt("s1_left_pulses", 0, 4);
    check_cnt("s1_right_pulses", 1, 0);
    step_n(5);

    // Left held, right pressed: right wins, DAS restarts; releasing right resumes nothing
    b[0] = 1'b1; step_n(10);
    clear_cnt();
    b[1] = 1'b1; step_n(30);
    check_cnt("s2_right_pulses", 1, 1);
    check_cnt("s2_left_after_right", 0, 0);
    clear_cnt();
    b[1] = 1'b0; step_n(60);
    check_cnt("s2_left_no_resume", 0, 0);
    check_cnt("s2_right_after_release", 1, 0);
    b[0] = 1'b0; step_n(5);

    // Down held 10 ticks: press + ticks 3, 6, 9
    align();
    clear_cnt();
    b[2] = 1'b1; step_n(100);
    b[2] = 1'b0; step_n(2);
    check_cnt("s3_down_pulses", 2, 4);

    // Same-cycle cw/ccw, then drop held
    clear_cnt();
    b[3] = 1'b1; b[4] = 1'b1; step_n(100);
    b[3] = 1'b0; b[4] = 1'b0; step_n(2);
    check_cnt("s4_cw_pulses", 3, 1);
    check_cnt("s4_ccw_pulses", 4, 0);
    clear_cnt();
    b[5] = 1'b1; step_n(50);
    b[5] = 1'b0; step_n(1);
    check_cnt("s4_drop_pulses", 5, 1);
    check_cnt("s4_drop_held_cycles", 7, 50);

    // Hold held across en rising: nothing until re-pressed
    en = 1'b0; b[6] = 1'b1; step_n(10);
    clear_cnt();
    en = 1'b1; step_n(20);
    check_cnt("s5_hold_no_action", 6, 0);
    b[6] = 1'b0; step_n(2);
    b[6] = 1'b1; step_n(5);
    check_cnt("s5_hold_repress", 6, 1);
    b[6] = 1'b0; step_n(3);

    // Reset mid-ARR with left held
    b[0] = 1'b1; step_n(80);
    rst_n = 1'b0;
    #1;
    check_outputs(8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cyc += 2;
    check_outputs(8'h00);
    rst_n = 1'b1;
    clear_cnt();
    step_n(30);
    check_cnt("s6_left_after_reset", 0, 1);
    b[0] = 1'b0; step_n(3);

    // Random traffic with random ticks, then with regular ticks
    tick_rand = 1'b1;
    repeat (3000) begin
      for (int i = 0; i < 7; i++) if ($urandom_range(15) == 0) b[i] = ~b[i];
      if ($urandom_range(63) == 0) en = ~en;
      step();
    end
    tick_rand = 1'b0;
    repeat (2000) begin
      for (int i = 0; i < 7; i++) if ($urandom_range(31) == 0) b[i] = ~b[i];
      if ($urandom_range(127) == 0) en = ~en;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
